// File: rtl/mem_io_responder.sv
// MemIO memory-side endpoint: line refills and write-backs
// served from on-chip RAM with a fixed read latency.
module mem_io_responder #(
  parameter int ADDR_BITS     = 26,
  parameter int TAG_BITS      = 5,
  parameter int DATA_BITS     = 128,
  parameter int BEATS         = 4,
  parameter int LINE_IDX_BITS = 10,
  parameter int READ_LATENCY  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_mem_req_cmd_valid,
  output logic                 io_mem_req_cmd_ready,
  input  logic                 io_mem_req_cmd_bits_rw,
  input  logic [ADDR_BITS-1:0] io_mem_req_cmd_bits_addr,
  input  logic [TAG_BITS-1:0]  io_mem_req_cmd_bits_tag,
  input  logic                 io_mem_req_data_valid,
  output logic                 io_mem_req_data_ready,
  input  logic [DATA_BITS-1:0] io_mem_req_data_bits_data,
  output logic                 io_mem_resp_valid,
  input  logic                 io_mem_resp_ready,
  output logic [TAG_BITS-1:0]  io_mem_resp_bits_tag,
  output logic [DATA_BITS-1:0] io_mem_resp_bits_data,
  output logic [31:0]          io_reads_done,
  output logic [31:0]          io_writes_done
);

  localparam int BEAT_BITS = $clog2(BEATS);
  localparam int IDX_BITS  = LINE_IDX_BITS + BEAT_BITS;
  localparam int DEPTH     = 1 << IDX_BITS;
  localparam int LAT_BITS  = $clog2(READ_LATENCY) + 1;

  typedef enum logic [1:0] {
    IDLE, WDATA, RWAIT, RRESP
  } state_t;

  state_t state_q, state_d;

  logic [LINE_IDX_BITS-1:0] line_q;
  logic [TAG_BITS-1:0]      tag_q;
  logic [BEAT_BITS-1:0]     beat_q;
  logic [LAT_BITS-1:0]      lat_q;
  logic [DATA_BITS-1:0]     rd_q;
  logic [31:0]              rd_cnt_q;
  logic [31:0]              wr_cnt_q;

  logic [DATA_BITS-1:0] ram [DEPTH];

  logic                 cmd_fire;
  logic                 data_fire;
  logic                 resp_fire;
  logic                 last_beat;
  logic                 ram_we;
  logic                 ram_re;
  logic [BEAT_BITS-1:0] rd_beat;
  logic [IDX_BITS-1:0]  ram_idx;

  // Upper line-address bits alias away by design.
  logic unused_addr_hi;
  assign unused_addr_hi =
    ^io_mem_req_cmd_bits_addr[ADDR_BITS-1:LINE_IDX_BITS];

  assign cmd_fire  = io_mem_req_cmd_valid && io_mem_req_cmd_ready;
  assign data_fire = io_mem_req_data_valid && io_mem_req_data_ready;
  assign resp_fire = io_mem_resp_valid && io_mem_resp_ready;
  assign last_beat = beat_q == BEAT_BITS'(BEATS - 1);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (cmd_fire)
          state_d = io_mem_req_cmd_bits_rw ? WDATA : RWAIT;
      WDATA:
        if (data_fire && last_beat) state_d = IDLE;
      RWAIT:
        if (lat_q == '0) state_d = RRESP;
      RRESP:
        if (resp_fire && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    io_mem_req_cmd_ready  = state_q == IDLE;
    io_mem_req_data_ready = state_q == WDATA;
    io_mem_resp_valid     = state_q == RRESP;
    io_mem_resp_bits_tag  = tag_q;
    io_mem_resp_bits_data = rd_q;
    io_reads_done         = rd_cnt_q;
    io_writes_done        = wr_cnt_q;
  end

  // Single RAM port: write beat, or prefetch the beat shown next.
  always_comb begin
    ram_we  = data_fire;
    ram_re  = (state_q == RWAIT && lat_q == '0) ||
              (resp_fire && !last_beat);
    rd_beat = (state_q == RRESP) ? beat_q + BEAT_BITS'(1) : '0;
    ram_idx = {line_q, ram_we ? beat_q : rd_beat};
  end

  // Line RAM, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= io_mem_req_data_bits_data;
  end

  // Transaction context, counters and read-data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q   <= '0;
      tag_q    <= '0;
      beat_q   <= '0;
      lat_q    <= '0;
      rd_q     <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (cmd_fire) begin
        line_q <= io_mem_req_cmd_bits_addr[LINE_IDX_BITS-1:0];
        tag_q  <= io_mem_req_cmd_bits_tag;
        beat_q <= '0;
        lat_q  <= LAT_BITS'(READ_LATENCY - 1);
      end
      if (state_q == RWAIT && lat_q != '0)
        lat_q <= lat_q - LAT_BITS'(1);
      if (data_fire || resp_fire)
        beat_q <= beat_q + BEAT_BITS'(1);
      if (data_fire && last_beat)
        wr_cnt_q <= wr_cnt_q + 32'd1;
      if (resp_fire && last_beat)
        rd_cnt_q <= rd_cnt_q + 32'd1;
      if (ram_re)
        rd_q <= ram[ram_idx];
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with a line-level
// memory model and a per-cycle response scoreboard.
module tb_mem_io_responder;

  localparam int AB = 26;
  localparam int TB = 5;
  localparam int DB = 128;
  localparam int NB = 4;
  localparam int LINES = 1024;
  localparam int LAT = 8;

  typedef struct {
    logic [TB-1:0] tag;
    logic [DB-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_rw = 1'b0;
  logic [AB-1:0] cmd_addr = '0;
  logic [TB-1:0] cmd_tag = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic [DB-1:0] data_bits = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [TB-1:0] resp_tag;
  logic [DB-1:0] resp_data;
  logic [31:0]   reads_done;
  logic [31:0]   writes_done;

  mem_io_responder dut (
    .clk                       (clk),
    .reset                     (reset),
    .io_mem_req_cmd_valid      (cmd_valid),
    .io_mem_req_cmd_ready      (cmd_ready),
    .io_mem_req_cmd_bits_rw    (cmd_rw),
    .io_mem_req_cmd_bits_addr  (cmd_addr),
    .io_mem_req_cmd_bits_tag   (cmd_tag),
    .io_mem_req_data_valid     (data_valid),
    .io_mem_req_data_ready     (data_ready),
    .io_mem_req_data_bits_data (data_bits),
    .io_mem_resp_valid         (resp_valid),
    .io_mem_resp_ready         (resp_ready),
    .io_mem_resp_bits_tag      (resp_tag),
    .io_mem_resp_bits_data     (resp_data),
    .io_reads_done             (reads_done),
    .io_writes_done            (writes_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [DB-1:0] mem_m [LINES][NB];
  int            rd_m = 0;
  int            wr_m = 0;
  beat_t         expq [$];
  logic [DB-1:0] got  [$];

  function automatic void check(input string name,
                                input logic [DB-1:0] act,
                                input logic [DB-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Scoreboard: every valid beat must match the next expected one.
  always @(negedge clk) begin
    if (reset) begin
      expq.delete();
    end else if (resp_valid) begin
      if (expq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL resp_unexpected: got %0h expected none",
                 resp_data);
      end else begin
        check("resp_tag", DB'(resp_tag), DB'(expq[0].tag));
        check("resp_data", resp_data, expq[0].data);
        if (resp_ready) begin
          got.push_back(resp_data);
          void'(expq.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic rw, input int addr,
                          input int tag);
    bit ok;
    int n;
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = AB'(addr);
    cmd_tag   = TB'(tag);
    n = 0;
    forever begin
      ok = cmd_ready;
      tick();
      n++;
      if (ok) break;
      if (n > 100) begin
        check("cmd_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic write_line(input int addr,
                            input logic [DB-1:0] d [NB],
                            input int gaps [NB],
                            input bit hold_cmd);
    bit ok;
    int n;
    send_cmd(1'b1, addr, 0);
    cmd_valid = hold_cmd;
    for (int b = 0; b < NB; b++) begin
      for (int g = 0; g < gaps[b]; g++) begin
        data_valid = 1'b0;
        if (hold_cmd) check("cmd_ready_wdata", DB'(cmd_ready), 0);
        tick();
      end
      data_valid = 1'b1;
      data_bits  = d[b];
      n = 0;
      forever begin
        ok = data_ready;
        if (hold_cmd) check("cmd_ready_wdata", DB'(cmd_ready), 0);
        tick();
        n++;
        if (ok) break;
        if (n > 100) begin
          check("data_timeout", 0, 1);
          break;
        end
      end
      mem_m[addr % LINES][b] = d[b];
    end
    cmd_valid  = 1'b0;
    data_valid = 1'b0;
    wr_m++;
    check("cmd_ready_after_w", DB'(cmd_ready), 1);
  endtask

  task automatic read_line(input int addr, input int tag,
                           input bit pat [$],
                           input int abort_after);
    int n;
    int fires;
    int i;
    bit f;
    for (int b = 0; b < NB; b++)
      expq.push_back('{TB'(tag), mem_m[addr % LINES][b]});
    send_cmd(1'b0, addr, tag);
    cmd_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 100) begin
      if (cmd_ready) check("cmd_ready_rwait", DB'(cmd_ready), 0);
      tick();
      n++;
    end
    check("read_latency", DB'(n), DB'(LAT));
    fires = 0;
    i = 0;
    while (fires < NB && i < 200) begin
      if (abort_after > 0 && fires == abort_after) break;
      resp_ready = (i < pat.size()) ? pat[i] : 1'b1;
      check("cmd_ready_rresp", DB'(cmd_ready), 0);
      f = resp_valid && resp_ready;
      tick();
      if (f) fires++;
      i++;
    end
    resp_ready = 1'b0;
    if (abort_after > 0) begin
      #2 reset = 1'b1;
      #1;
      check("rst_resp_valid", DB'(resp_valid), 0);
      check("rst_cmd_ready", DB'(cmd_ready), 1);
      check("rst_reads", DB'(reads_done), 0);
      check("rst_writes", DB'(writes_done), 0);
      tick();
      reset = 1'b0;
      rd_m = 0;
      wr_m = 0;
    end else begin
      check("read_beats", DB'(fires), DB'(NB));
      check("resp_valid_end", DB'(resp_valid), 0);
      check("cmd_ready_end", DB'(cmd_ready), 1);
      rd_m++;
    end
  endtask

  task automatic check_counts();
    check("reads_done", DB'(reads_done), DB'(rd_m));
    check("writes_done", DB'(writes_done), DB'(wr_m));
  endtask

  task automatic check_got(input string name, input int base);
    check({name, "_cnt"}, DB'(got.size()), DB'(NB));
    for (int b = 0; b < NB && b < got.size(); b++)
      check(name, got[b], DB'(base + b));
    got.delete();
  endtask

  logic [DB-1:0] d [NB];
  int            gz [NB];
  int            gv [NB];
  bit            all1 [$];
  bit            tog [$];

  initial begin
    gz = '{0, 0, 0, 0};
    gv = '{0, 3, 1, 2};
    tog = '{1, 0, 0, 1, 0, 1, 1};
    tick();
    tick();
    check("rst_cmd_ready0", DB'(cmd_ready), 1);
    check("rst_data_ready0", DB'(data_ready), 0);
    check("rst_resp_valid0", DB'(resp_valid), 0);
    check("rst_tag0", DB'(resp_tag), 0);
    check("rst_data0", resp_data, 0);
    check("rst_cnt0", DB'(reads_done), 0);
    reset = 1'b0;
    tick();

    data_valid = 1'b1;
    data_bits  = 128'hDEAD;
    check("idle_data_ready", DB'(data_ready), 0);
    tick();
    data_valid = 1'b0;

    d = '{128'hA0, 128'hA1, 128'hA2, 128'hA3};
    write_line(32'h10, d, gz, 1'b0);
    read_line(32'h10, 7, all1, 0);
    check_got("t1_data", 32'hA0);
    check_counts();
    check("t1_writes_lit", DB'(writes_done), 1);
    check("t1_reads_lit", DB'(reads_done), 1);

    read_line(32'h10, 7, tog, 0);
    check_got("t2_data", 32'hA0);
    check_counts();

    d = '{128'hB0, 128'hB1, 128'hB2, 128'hB3};
    write_line(32'h3, d, gz, 1'b0);
    d = '{128'hC0, 128'hC1, 128'hC2, 128'hC3};
    write_line(32'h403, d, gv, 1'b1);
    read_line(32'h3, 9, tog, 0);
    check_got("alias_data", 32'hC0);
    check_counts();

    d = '{128'h200, 128'h201, 128'h202, 128'h203};
    write_line(32'h20, d, gv, 1'b1);
    d = '{128'h210, 128'h211, 128'h212, 128'h213};
    write_line(32'h21, d, gz, 1'b0);
    read_line(32'h20, 1, all1, 0);
    read_line(32'h21, 2, all1, 0);
    check("b2b_cnt", DB'(got.size()), DB'(2 * NB));
    for (int b = 0; b < NB && 2 * NB <= got.size(); b++) begin
      check("b2b_first", got[b], DB'(32'h200 + b));
      check("b2b_second", got[NB + b], DB'(32'h210 + b));
    end
    got.delete();
    check_counts();

    read_line(32'h10, 4, all1, 2);
    got.delete();
    tick();
    check("post_rst_cmd_ready", DB'(cmd_ready), 1);
    check_counts();
    read_line(32'h10, 5, tog, 0);
    check_got("reread_data", 32'hA0);
    check_counts();

    tick();
    check("queue_drained", DB'(expq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
